// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;

  // Width of the overflow compare. It is wide enough to hold 10^10-1.
  localparam int LIMIT_W = 34;

  localparam logic [3:0] BCD_NINE = 4'h9;

  // Largest value representable in 'digits' BCD digits, i.e. 10^digits - 1.
  function automatic logic [LIMIT_W-1:0] bcd_limit(input int digits);
    logic [LIMIT_W-1:0] v;
    v = 34'd1;
    for (int i = 0; i < digits; i++) begin
      v = v * 34'd10;
    end
    return v - 34'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_dabble.sv
// One double-dabble correction cell: a nibble of 5 or more gets +3, so that
// the following left shift carries into the next decimal digit.
module dabble_nibble (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // add-3 correction for digits that would reach 10 or more after doubling
  always_comb begin
    adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter. It runs one add-3/shift step per clock
// for exactly WIDTH clocks. Results are held stable between done pulses, so
// the display never sees partial accumulator values.
import bin2bcd_pkg::*;

module bin2bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_mask,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LIMIT_W-1:0] LIMIT = bcd_limit(DIGITS);

  b2b_state_t        state;
  b2b_state_t        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  bin_sr;
  logic [BCD_W-1:0]  acc;
  logic [BCD_W-1:0]  acc_adj;
  logic [BCD_W-1:0]  acc_next;
  logic [BCD_W-1:0]  result;
  logic              ovf_pending;
  logic              accept;
  logic              last;

  // A digit is significant when it, or any digit above it, is non-zero.
  // Digit 0 always shows, so zero is displayed as a single "0".
  function automatic logic [DIGITS-1:0] sig_mask(input logic [BCD_W-1:0] v);
    logic [DIGITS-1:0] m;
    logic              seen;
    m    = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen = seen | (v[4*i +: 4] != 4'd0);
      m[i] = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dabble
      dabble_nibble u_dabble (
        .digit    (acc[4*g +: 4]),
        .adjusted (acc_adj[4*g +: 4])
      );
    end
  endgenerate

  // Corrected accumulator shifted left, with the next binary MSB entering at the bottom.
  // The top accumulator bit falls off, which happens only in saturated cases.
  assign acc_next = {acc_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
  assign result   = ovf_pending ? {DIGITS{BCD_NINE}} : acc_next;
  assign accept   = (state != SHIFT) && start;
  assign last     = (state == SHIFT) && (cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status decode; start is only looked at outside SHIFT
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        state_next = start ? SHIFT : IDLE;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? SHIFT : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Iteration counter and saturation flag, both set up when a start is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      ovf_pending <= 1'b0;
    end else if (accept) begin
      cnt         <= CNT_W'(WIDTH - 1);
      ovf_pending <= ({{(LIMIT_W - WIDTH){1'b0}}, bin_in} > LIMIT);
    end else if ((state == SHIFT) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Shift datapath: capture on accept, one dabble step per SHIFT cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      bin_sr <= bin_in;
      acc    <= '0;
    end else if (state == SHIFT) begin
      bin_sr <= bin_sr << 1;
      acc    <= acc_next;
    end
  end

  // Output registers, updated only on the final shift so they hold between results
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_out    <= '0;
      digit_mask <= DIGITS'(1);
      overflow   <= 1'b0;
    end else if (last) begin
      bcd_out    <= result;
      digit_mask <= sig_mask(result);
      overflow   <= ovf_pending;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq. It builds a 32-bit/8-digit instance and an
// 8-bit/3-digit instance. A scoreboard queue holds the expected result and
// the expected done cycle for every accepted start.
module tb_bin2bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] bin_in;
  logic        busy;
  logic        done;
  logic [31:0] bcd_out;
  logic [7:0]  digit_mask;
  logic        overflow;

  logic        start8;
  logic [7:0]  bin8;
  logic        busy8;
  logic        done8;
  logic [11:0] bcd8;
  logic [2:0]  mask8;
  logic        ovf8;

  bin2bcd_seq #(.WIDTH(32), .DIGITS(8)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .bcd_out    (bcd_out),
    .digit_mask (digit_mask),
    .overflow   (overflow)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk        (clk),
    .reset      (reset),
    .start      (start8),
    .bin_in     (bin8),
    .busy       (busy8),
    .done       (done8),
    .bcd_out    (bcd8),
    .digit_mask (mask8),
    .overflow   (ovf8)
  );

  typedef struct {
    logic [31:0] bin;
    logic [31:0] bcd;
    logic [7:0]  mask;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  mask;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t got_exp;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   busy_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Scoreboard: compare every done pulse against the oldest pending expectation
  always @(negedge clk) begin
    if (busy) busy_run++;
    else if (!done) busy_run = 0;
    if (done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with nothing pending, bcd_out=%h (cycle %0d)", bcd_out, cyc);
      end else begin
        got_exp = sb.pop_front();
        chk("bcd_out", {32'd0, bcd_out}, {32'd0, got_exp.bcd});
        chk("digit_mask", {56'd0, digit_mask}, {56'd0, got_exp.mask});
        chk("overflow", {63'd0, overflow}, {63'd0, got_exp.ovf});
        chk("done_cycle", 64'(cyc), 64'(got_exp.due));
        chk("busy_cycles", 64'(busy_run), 64'd32);
      end
      busy_run = 0;
    end
  end

  // Drive one cycle of stimulus; if the DUT will accept the start, queue the expectation
  task automatic drive(input logic s, input logic [31:0] b,
                       input logic [31:0] eb, input logic [7:0] em, input logic eo);
    @(negedge clk);
    start  = s;
    bin_in = b;
    if (s && !busy) sb.push_back('{bcd: eb, mask: em, ovf: eo, due: cyc + 33});
  endtask

  // Drop start and wait (bounded) until every queued conversion has completed
  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    start = 1'b0;
    while ((sb.size() != 0 || busy || done) && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL %s_timeout: pending=%0d busy=%0b after %0d cycles", tag, sb.size(), busy, k);
    end
  endtask

  vec_t        vt[8];
  logic [7:0]  v8[3];
  logic [11:0] e8[3];
  logic [2:0]  m8[3];
  int          n0;
  int          k;
  int          pushes;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = 32'd0;
    start8 = 1'b0;
    bin8   = 8'd0;

    vt[0] = '{bin: 32'd0,         bcd: 32'h00000000, mask: 8'h01, ovf: 1'b0};
    vt[1] = '{bin: 32'd305,       bcd: 32'h00000305, mask: 8'h07, ovf: 1'b0};
    vt[2] = '{bin: 32'd12345678,  bcd: 32'h12345678, mask: 8'hFF, ovf: 1'b0};
    vt[3] = '{bin: 32'd99999999,  bcd: 32'h99999999, mask: 8'hFF, ovf: 1'b0};
    vt[4] = '{bin: 32'd100000000, bcd: 32'h99999999, mask: 8'hFF, ovf: 1'b1};
    vt[5] = '{bin: 32'hFFFFFFFF,  bcd: 32'h99999999, mask: 8'hFF, ovf: 1'b1};
    vt[6] = '{bin: 32'd10,        bcd: 32'h00000010, mask: 8'h03, ovf: 1'b0};
    vt[7] = '{bin: 32'd9000000,   bcd: 32'h09000000, mask: 8'h7F, ovf: 1'b0};

    v8[0] = 8'd255; e8[0] = 12'h255; m8[0] = 3'b111;
    v8[1] = 8'd7;   e8[1] = 12'h007; m8[1] = 3'b001;
    v8[2] = 8'd100; e8[2] = 12'h100; m8[2] = 3'b111;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_bcd", {32'd0, bcd_out}, 64'd0);
    chk("rst_mask", {56'd0, digit_mask}, 64'd1);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    chk("rst_mask8", {61'd0, mask8}, 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // table-driven conversions
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vt[i].bin, vt[i].bcd, vt[i].mask, vt[i].ovf);
      wait_idle("vec");
    end
    repeat (5) @(negedge clk);
    chk("hold_bcd", {32'd0, bcd_out}, {32'd0, 32'h09000000});
    chk("hold_mask", {56'd0, digit_mask}, 64'h7F);

    // start held high through busy: no recapture, back-to-back from the done cycle
    drive(1'b1, 32'd42, 32'h00000042, 8'h03, 1'b0);
    pushes = 0;
    k = 0;
    while (pushes < 1 && k < 80) begin
      @(negedge clk);
      start  = 1'b1;
      bin_in = 32'd7;
      if (!busy) begin
        sb.push_back('{bcd: 32'h00000007, mask: 8'h01, ovf: 1'b0, due: cyc + 33});
        pushes++;
      end
      k++;
    end
    chk("b2b_accepted", 64'(pushes), 64'd1);
    wait_idle("b2b");

    // reset in the middle of a conversion
    @(negedge clk);
    start  = 1'b1;
    bin_in = 32'd999;
    n0     = cyc;
    @(negedge clk);
    start  = 1'b0;
    while (cyc < n0 + 10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_bcd", {32'd0, bcd_out}, 64'd0);
    chk("abort_mask", {56'd0, digit_mask}, 64'd1);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    drive(1'b1, 32'd5, 32'h00000005, 8'h01, 1'b0);
    wait_idle("post_abort");

    // narrow instance: 8-bit input, 3 digits
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start8 = 1'b1;
      bin8   = v8[i];
      n0     = cyc;
      @(negedge clk);
      start8 = 1'b0;
      k = 0;
      while (!done8 && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("w8_done_cycle", 64'(cyc), 64'(n0 + 9));
      chk("w8_bcd", {52'd0, bcd8}, {52'd0, e8[i]});
      chk("w8_mask", {61'd0, mask8}, {61'd0, m8[i]});
      chk("w8_ovf", {63'd0, ovf8}, 64'd0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential double-dabble converter that turns an unsigned binary value into packed BCD digits. It sits directly upstream of the seven-segment display driver, and its packed BCD output is the 32-bit word that driver consumes. It also produces a leading-zero significance mask and an overflow flag, so the display side can blank unused digits or flag saturation. It uses one shift/add-3 iteration per clock, so it needs no wide divider.

Parameters:
WIDTH, 32, bit width of the binary input (1..32)
DIGITS, 8, number of BCD output digits; output is 4*DIGITS bits (1..10)

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a conversion; sampled only when not busy
bin_in  input  WIDTH  unsigned binary value; captured in the cycle start is accepted
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; bcd_out, digit_mask and overflow are new this cycle
bcd_out  output  4*DIGITS  packed BCD; digit i is bits [4i+3:4i], digit 0 is the least significant
digit_mask  output  DIGITS  bit i = 1 if digit i is significant (leading-zero blanking)
overflow  output  1  bin_in exceeded 10^DIGITS-1 on the last conversion

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state IDLE, busy=0, done=0, bcd_out=0, digit_mask = 1 (only bit 0 set), overflow=0, iteration counter=0.
- Reset asserted mid-conversion: the conversion is aborted with no done pulse, and all outputs return to their reset values on the next edge.
- States: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1:
  - bin_in is captured into the binary shift register and the BCD accumulator is cleared.
  - ovf_pending is set to (bin_in > 10^DIGITS-1).
  - Counter is loaded with WIDTH-1 and the block goes to SHIFT.
- IDLE or DONE with start=0: the block goes to (or stays in) IDLE.
- SHIFT, each cycle:
  - Every accumulator nibble >= 5 gets +3.
  - Then {accumulator, binary register} shifts left by 1.
  - When the counter reaches 0, the block goes to DONE; otherwise the counter decrements.
- Exactly WIDTH SHIFT cycles run, regardless of the input value, so latency is fixed.
- Result load on the SHIFT->DONE edge:
  - bcd_out is the accumulator, or all digits 4'h9 if ovf_pending.
  - overflow takes ovf_pending.
  - digit_mask bit i = OR of (digit j != 0) for j >= i; bit 0 is always 1.
- busy=1 exactly while in SHIFT. done=1 exactly while in DONE (one cycle).
- Latency: if start is accepted in cycle N, busy is high in cycles N+1..N+WIDTH and done is high in cycle N+WIDTH+1.
- start while busy is ignored: no queueing, and bin_in is not recaptured.
- start during the done cycle is accepted, giving back-to-back conversions with one cycle of gap.
- Hold: bcd_out, digit_mask and overflow keep their values until the next done or a reset. The downstream display therefore never sees intermediate accumulator values.
- Width rules:
  - The accumulator is 4*DIGITS bits; bits shifted out of its top are discarded. This only happens in overflow cases, which are masked by saturation.
  - The overflow compare is done at capture against a constant of width max(WIDTH, 34).

Decomposition:
- Package bin2bcd_pkg contains:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;
  - constant function bcd_limit(DIGITS), returning 10^DIGITS-1 as a 34-bit value;
  - constant BCD_NINE = 4'h9.
- One combinational sub-module, dabble_nibble: a 4-bit input that outputs in+3 if in >= 5, else in. It is instantiated DIGITS times via generate.
- The FSM, counter and registers stay in bin2bcd_seq.

Test Plan:
1. Reset, then start with bin_in=0 -> done in cycle N+33; bcd_out=32'h00000000, digit_mask=8'b00000001, overflow=0; busy high for exactly 32 cycles.
2. bin_in=305, then bin_in=12345678 -> bcd_out=32'h00000305 with digit_mask=8'b00000111; then bcd_out=32'h12345678 with digit_mask=8'hFF.
3. bin_in=99999999 -> bcd_out=32'h99999999, overflow=0. bin_in=100000000 -> bcd_out=32'h99999999, overflow=1. bin_in=32'hFFFFFFFF -> overflow=1.
4. start=1 with bin_in=42, then hold start=1 while driving bin_in=7 throughout busy -> the first result is 32'h00000042. The second conversion starts in the done cycle and its result is 32'h00000007, with done exactly 33 cycles after the first done.
5. Start bin_in=999 and assert reset at cycle N+10 -> no done pulse; next cycle busy=0, bcd_out=0, digit_mask=8'b00000001. A new start with bin_in=5 then yields 32'h00000005.
6. Parameter sweep WIDTH=8, DIGITS=3: bin_in=255 -> bcd_out=12'h255, done at N+9, overflow=0.
